// File: rtl/pic_pkg.sv
// Shared constants and bit-manipulation helpers for the 8-line priority resolver.
package pic_pkg;

  localparam int unsigned NUM_IR = 8;
  localparam int unsigned IDX_W  = 3;

  // Reported as interrupt_id when a grant pulse finds nothing eligible.
  localparam logic [IDX_W-1:0] SPURIOUS_ID = IDX_W'(7);

  function automatic logic [NUM_IR-1:0] rotate_right(input logic [NUM_IR-1:0] value,
                                                     input logic [IDX_W-1:0]  amount);
    logic [2*NUM_IR-1:0] doubled;
    doubled = {value, value} >> amount;
    return doubled[NUM_IR-1:0];
  endfunction

  function automatic logic [NUM_IR-1:0] rotate_left(input logic [NUM_IR-1:0] value,
                                                    input logic [IDX_W-1:0]  amount);
    logic [2*NUM_IR-1:0] doubled;
    doubled = {value, value} << amount;
    return doubled[2*NUM_IR-1:NUM_IR];
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_index(input logic [NUM_IR-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_IR; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // Position in the current priority order: 0 is highest, i.e. level L+1.
  function automatic logic [IDX_W-1:0] priority_rank(input logic [IDX_W-1:0] idx,
                                                     input logic [IDX_W-1:0] lowest);
    return IDX_W'(idx - lowest - IDX_W'(1));
  endfunction

endpackage

// File: rtl/priority_resolver_if.sv
// Request/service bus between the interrupt controller core and its resolver.
interface priority_resolver_if;
  import pic_pkg::*;

  logic [NUM_IR-1:0] ir_in;
  logic              level_edge_triggered;
  logic [NUM_IR-1:0] int_mask;
  logic [NUM_IR-1:0] eoi;
  logic [IDX_W-1:0]  priority_rotate;
  logic              latch_in_service;

  logic [NUM_IR-1:0] interrupt_request_register;
  logic [NUM_IR-1:0] in_service_register;
  logic [NUM_IR-1:0] highest_level_in_service;
  logic              interrupt_out;
  logic [IDX_W-1:0]  interrupt_id;

  modport master (
    output ir_in, level_edge_triggered, int_mask, eoi, priority_rotate, latch_in_service,
    input  interrupt_request_register, in_service_register, highest_level_in_service,
           interrupt_out, interrupt_id
  );

  modport slave (
    input  ir_in, level_edge_triggered, int_mask, eoi, priority_rotate, latch_in_service,
    output interrupt_request_register, in_service_register, highest_level_in_service,
           interrupt_out, interrupt_id
  );

endinterface

// File: rtl/priority_resolver_encoder.sv
// Combinational rotating priority encoder: picks the highest-priority set request
// when level `rotation` is the lowest priority and (rotation+1) mod 8 the highest.
module rotating_priority_encoder
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] request,
  input  logic [IDX_W-1:0]  rotation,
  output logic [NUM_IR-1:0] onehot_c,
  output logic              valid_c
);

  logic [IDX_W-1:0]  shift;
  logic [NUM_IR-1:0] rotated;
  logic [NUM_IR-1:0] lowest;

  // Rotate the top-priority line down to bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    shift    = IDX_W'(rotation + IDX_W'(1));
    rotated  = rotate_right(request, shift);
    lowest   = rotated & NUM_IR'(~rotated + NUM_IR'(1));
    onehot_c = rotate_left(lowest, shift);
    valid_c  = |request;
  end

endmodule

// File: rtl/priority_resolver.sv
// Interrupt priority resolver: request capture (edge/level), masking, rotating
// priority selection, in-service tracking and the registered INT request.
module priority_resolver
  import pic_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  priority_resolver_if.slave  pic
);

  logic [NUM_IR-1:0] ir_prev;
  logic [NUM_IR-1:0] irr;
  logic [NUM_IR-1:0] isr;
  logic              int_q;
  logic [IDX_W-1:0]  id_q;

  logic [NUM_IR-1:0] edges;
  logic [NUM_IR-1:0] pending;
  logic [NUM_IR-1:0] candidate;
  logic              cand_valid;
  logic [NUM_IR-1:0] hlis;
  logic              hlis_valid;
  logic [NUM_IR-1:0] grant;
  logic [IDX_W-1:0]  cand_idx;
  logic [IDX_W-1:0]  hlis_idx;
  logic              cand_higher;
  logic              int_next;
  logic [NUM_IR-1:0] irr_next;
  logic [NUM_IR-1:0] isr_next;
  logic [IDX_W-1:0]  id_next;

  rotating_priority_encoder u_candidate (
    .request  (pending),
    .rotation (pic.priority_rotate),
    .onehot_c (candidate),
    .valid_c  (cand_valid)
  );

  rotating_priority_encoder u_in_service (
    .request  (isr),
    .rotation (pic.priority_rotate),
    .onehot_c (hlis),
    .valid_c  (hlis_valid)
  );

  always_comb begin
    edges       = pic.ir_in & ~ir_prev;
    pending     = irr & ~pic.int_mask;
    grant       = pic.latch_in_service ? candidate : '0;
    cand_idx    = onehot_to_index(candidate);
    hlis_idx    = onehot_to_index(hlis);
    cand_higher = priority_rank(cand_idx, pic.priority_rotate)
                < priority_rank(hlis_idx, pic.priority_rotate);
    int_next    = cand_valid && (!hlis_valid || cand_higher);

    // Grant clears before new edges are ORed in, so a same-cycle edge re-arms the bit.
    if (pic.level_edge_triggered) irr_next = pic.ir_in & ~grant;
    else                          irr_next = (irr & ~grant) | edges;

    // Grant set is applied after EOI clear, so set wins on a collision.
    isr_next = (isr & ~pic.eoi) | grant;

    id_next = id_q;
    if (pic.latch_in_service) id_next = cand_valid ? cand_idx : SPURIOUS_ID;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_prev <= '1;
      irr     <= '0;
      isr     <= '0;
      int_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      ir_prev <= pic.ir_in;
      irr     <= irr_next;
      isr     <= isr_next;
      int_q   <= int_next;
      id_q    <= id_next;
    end
  end

  assign pic.interrupt_request_register = irr;
  assign pic.in_service_register        = isr;
  assign pic.highest_level_in_service   = hlis;
  assign pic.interrupt_out              = int_q;
  assign pic.interrupt_id               = id_q;

endmodule

// File: tb/tb_priority_resolver.sv
// Scoreboard bench for priority_resolver: expectations are queued with each stimulus
// cycle and compared against the outputs just after the following rising edge.
module tb_priority_resolver;
  import pic_pkg::*;

  typedef enum logic [2:0] {F_IRR, F_ISR, F_HLIS, F_INT, F_ID} field_e;
  typedef struct packed {
    field_e     fld;
    logic [7:0] val;
  } exp_t;

  logic clk;
  logic reset;

  priority_resolver_if pic();

  priority_resolver dut (
    .clk   (clk),
    .reset (reset),
    .pic   (pic)
  );

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp;
  int    n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] observe(input field_e fld);
    case (fld)
      F_IRR:   return pic.interrupt_request_register;
      F_ISR:   return pic.in_service_register;
      F_HLIS:  return pic.highest_level_in_service;
      F_INT:   return {7'd0, pic.interrupt_out};
      default: return {5'd0, pic.interrupt_id};
    endcase
  endfunction

  task automatic expect_val(input string tag, input field_e fld, input logic [7:0] val);
    exp_t e;
    e.fld = fld;
    e.val = val;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Advance one clock, then retire every expectation queued for this edge.
  task automatic tick();
    exp_t  e;
    string t;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, observe(e.fld), e.val);
    end
  endtask

  task automatic drive_idle();
    pic.ir_in                = 8'h00;
    pic.level_edge_triggered = 1'b0;
    pic.int_mask             = 8'h00;
    pic.eoi                  = 8'h00;
    pic.priority_rotate      = 3'd7;
    pic.latch_in_service     = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    drive_idle();
    reset = 1'b1;
    tick();
    expect_val({tag, "_irr"},  F_IRR,  8'h00);
    expect_val({tag, "_isr"},  F_ISR,  8'h00);
    expect_val({tag, "_hlis"}, F_HLIS, 8'h00);
    expect_val({tag, "_int"},  F_INT,  8'h00);
    expect_val({tag, "_id"},   F_ID,   8'h00);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    drive_idle();

    // Basic edge capture and grant, L = 7 (IR0 highest)
    do_reset("rst0");
    tick();
    pic.ir_in = 8'h08; expect_val("s1_irr3", F_IRR, 8'h08); expect_val("s1_int_lat", F_INT, 8'h00); tick();
    pic.ir_in = 8'h20; expect_val("s1_irr35", F_IRR, 8'h28); expect_val("s1_int_on", F_INT, 8'h01); tick();
    pic.ir_in = 8'h00; expect_val("s1_irr_hold", F_IRR, 8'h28); tick();
    pic.latch_in_service = 1'b1;
    expect_val("s1_isr", F_ISR, 8'h08); expect_val("s1_id", F_ID, 8'h03);
    expect_val("s1_irr_after", F_IRR, 8'h20); expect_val("s1_hlis", F_HLIS, 8'h08);
    tick();
    pic.latch_in_service = 1'b0;
    expect_val("s1_int_off", F_INT, 8'h00); tick();

    // Rotation L = 4: IR5 outranks IR1
    do_reset("rst1");
    tick();
    pic.ir_in = 8'h22; expect_val("s2_irr", F_IRR, 8'h22); tick();
    pic.ir_in = 8'h00; pic.priority_rotate = 3'd4; pic.latch_in_service = 1'b1;
    expect_val("s2_isr", F_ISR, 8'h20); expect_val("s2_id", F_ID, 8'h05);
    expect_val("s2_irr", F_IRR, 8'h02); expect_val("s2_hlis", F_HLIS, 8'h20);
    tick();
    pic.latch_in_service = 1'b0;
    expect_val("s2_int_low", F_INT, 8'h00); tick();
    pic.priority_rotate = 3'd0;
    expect_val("s2_int_rot", F_INT, 8'h01); expect_val("s2_irr_keep", F_IRR, 8'h02);
    expect_val("s2_isr_keep", F_ISR, 8'h20); tick();

    // Nesting, EOI-vs-set and edge-vs-grant collisions
    do_reset("rst2");
    tick();
    pic.ir_in = 8'h10; expect_val("s3_irr4", F_IRR, 8'h10); tick();
    pic.ir_in = 8'h00; pic.latch_in_service = 1'b1;
    expect_val("s3_isr4", F_ISR, 8'h10); expect_val("s3_id4", F_ID, 8'h04); tick();
    pic.latch_in_service = 1'b0; pic.ir_in = 8'h04;
    expect_val("s3_irr2", F_IRR, 8'h04); expect_val("s3_int_pre", F_INT, 8'h00); tick();
    pic.ir_in = 8'h00;
    expect_val("s3_int_nest", F_INT, 8'h01); expect_val("s3_hlis4", F_HLIS, 8'h10); tick();
    pic.eoi = 8'h10; pic.latch_in_service = 1'b1;
    expect_val("s3_isr_nest", F_ISR, 8'h04); expect_val("s3_id2", F_ID, 8'h02); tick();
    pic.eoi = 8'h00; pic.latch_in_service = 1'b0;
    expect_val("s3_int_done", F_INT, 8'h00); expect_val("s3_hlis2", F_HLIS, 8'h04); tick();
    pic.ir_in = 8'h04; expect_val("s3_irr_again", F_IRR, 8'h04); tick();
    pic.ir_in = 8'h00; pic.eoi = 8'h04; pic.latch_in_service = 1'b1;
    expect_val("s3_eoi_vs_set", F_ISR, 8'h04); expect_val("s3_irr_clr", F_IRR, 8'h00); tick();
    pic.eoi = 8'h00; pic.latch_in_service = 1'b0; tick();
    pic.ir_in = 8'h04; tick();
    pic.ir_in = 8'h00; tick();
    pic.ir_in = 8'h04; pic.latch_in_service = 1'b1;
    expect_val("s3_edge_vs_grant", F_IRR, 8'h04); expect_val("s3_id_eg", F_ID, 8'h02); tick();
    pic.latch_in_service = 1'b0;

    // Level mode follows the line; grant clears the bit for one cycle
    do_reset("rst3");
    pic.level_edge_triggered = 1'b1;
    pic.ir_in = 8'h40; expect_val("s4_lvl_irr_a", F_IRR, 8'h40); expect_val("s4_lvl_int_a", F_INT, 8'h00); tick();
    expect_val("s4_lvl_irr_b", F_IRR, 8'h40); expect_val("s4_lvl_int_b", F_INT, 8'h01); tick();
    expect_val("s4_lvl_irr_c", F_IRR, 8'h40); tick();
    pic.ir_in = 8'h00; expect_val("s4_lvl_irr_drop", F_IRR, 8'h00); expect_val("s4_lvl_int_hold", F_INT, 8'h01); tick();
    expect_val("s4_lvl_int_drop", F_INT, 8'h00); tick();
    pic.ir_in = 8'h40; tick();
    pic.latch_in_service = 1'b1;
    expect_val("s4_lvl_grant_irr", F_IRR, 8'h00); expect_val("s4_lvl_isr", F_ISR, 8'h40);
    expect_val("s4_lvl_id", F_ID, 8'h06); tick();
    pic.latch_in_service = 1'b0;
    expect_val("s4_lvl_rearm", F_IRR, 8'h40); tick();

    // Edge mode under the same line pattern keeps IRR[6]
    do_reset("rst4");
    tick();
    pic.ir_in = 8'h40; expect_val("s4_edg_irr", F_IRR, 8'h40); tick();
    tick();
    tick();
    pic.ir_in = 8'h00; expect_val("s4_edg_hold", F_IRR, 8'h40); tick();
    expect_val("s4_edg_hold2", F_IRR, 8'h40); expect_val("s4_edg_int", F_INT, 8'h01); tick();

    // Spurious grant under full mask, then reset in mid-service
    do_reset("rst5");
    tick();
    pic.ir_in = 8'h01; tick();
    pic.ir_in = 8'h00; pic.int_mask = 8'hFF; pic.latch_in_service = 1'b1;
    expect_val("s5_spur_isr", F_ISR, 8'h00); expect_val("s5_spur_id", F_ID, 8'h07);
    expect_val("s5_mask_keep", F_IRR, 8'h01); tick();
    pic.latch_in_service = 1'b0;
    expect_val("s5_mask_int", F_INT, 8'h00); tick();
    pic.ir_in = 8'h80; pic.int_mask = 8'h7F;
    expect_val("s5_irr81", F_IRR, 8'h81); tick();
    pic.ir_in = 8'h00; pic.latch_in_service = 1'b1;
    expect_val("s5_isr80", F_ISR, 8'h80); expect_val("s5_hlis80", F_HLIS, 8'h80); tick();
    reset = 1'b1; pic.ir_in = 8'hFF; pic.latch_in_service = 1'b1; pic.eoi = 8'h00;
    expect_val("s5_rst_irr", F_IRR, 8'h00); expect_val("s5_rst_isr", F_ISR, 8'h00);
    expect_val("s5_rst_hlis", F_HLIS, 8'h00); expect_val("s5_rst_int", F_INT, 8'h00);
    expect_val("s5_rst_id", F_ID, 8'h00); tick();
    reset = 1'b0; pic.latch_in_service = 1'b0; pic.int_mask = 8'h00;
    expect_val("s5_rel_irr", F_IRR, 8'h00); tick();
    expect_val("s5_rel_irr2", F_IRR, 8'h00); expect_val("s5_rel_int", F_INT, 8'h00); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
